// File: rtl/pcie_us_msi_arb.sv
// rtl/pcie_us_msi_arb.sv - round-robin MSI request arbiter for the UltraScale cfg_interrupt_msi interface
// Optional build macro MSI_RETRY_LIMIT_EN: drop a request after RETRY_LIMIT consecutive send failures.
module pcie_us_msi_arb #(
   parameter int IRQ_COUNT   = 32,
   parameter int RETRY_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IRQ_COUNT-1:0] irq_req,
   input  logic [3:0]           cfg_interrupt_msi_enable,
   input  logic [11:0]          cfg_interrupt_msi_mmenable,
   input  logic                 cfg_interrupt_msi_mask_update,
   input  logic [31:0]          cfg_interrupt_msi_data,
   output logic [3:0]           cfg_interrupt_msi_select,
   output logic [31:0]          cfg_interrupt_msi_int,
   input  logic                 cfg_interrupt_msi_sent,
   input  logic                 cfg_interrupt_msi_fail,
   output logic [31:0]          cfg_interrupt_msi_pending_status,
   output logic                 cfg_interrupt_msi_pending_status_data_enable,
   output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
   output logic                 status_irq_drop,
   output logic [4:0]           status_irq_drop_index
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [IRQ_COUNT-1:0] pending_q, pending_d, clr;
   logic [31:0]          mask_q, mask_d;
   logic [4:0]           rr_ptr_q, rr_ptr_d;
   logic [4:0]           winner_q, winner_d;
   logic [3:0]           retry_q, retry_d;
   logic [31:0]          int_q, int_d;
   logic [31:0]          pstat_q, pstat_d;
   logic                 pstat_de_q, pstat_de_d;
   logic [4:0]           vmask;
   logic [4:0]           pick;
   logic                 found;
   logic [4:0]           rr_next;
   logic                 drop_d;

   logic unused_cfg_bits;
   assign unused_cfg_bits = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

   // Host may grant more vectors than 32; anything above 5 is clamped to 32 vectors.
   always_comb begin
      case (cfg_interrupt_msi_mmenable[2:0])
         3'd0:    vmask = 5'h00;
         3'd1:    vmask = 5'h01;
         3'd2:    vmask = 5'h03;
         3'd3:    vmask = 5'h07;
         3'd4:    vmask = 5'h0f;
         default: vmask = 5'h1f;
      endcase
   end

   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      for (int k = 0; k < IRQ_COUNT; k++) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= IRQ_COUNT) idx = idx - IRQ_COUNT;
         if (!found && pending_q[idx] && !mask_q[5'(idx) & vmask]) begin
            found = 1'b1;
            pick  = 5'(idx);
         end
      end
   end

   assign rr_next = (winner_q == 5'(IRQ_COUNT - 1)) ? 5'd0 : winner_q + 5'd1;

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      rr_ptr_d = rr_ptr_q;
      retry_d  = retry_q;
      int_d    = '0;
      clr      = '0;
      drop_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_interrupt_msi_enable[0] && found) begin
               winner_d = pick;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            int_d   = 32'd1 << (winner_q & vmask);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cfg_interrupt_msi_sent) begin
               clr[winner_q] = 1'b1;
               rr_ptr_d      = rr_next;
               retry_d       = '0;
               state_d       = S_IDLE;
            end else if (cfg_interrupt_msi_fail) begin
               state_d = S_IDLE;
`ifdef MSI_RETRY_LIMIT_EN
               if (int'(retry_q) + 1 >= RETRY_LIMIT) begin
                  clr[winner_q] = 1'b1;
                  rr_ptr_d      = rr_next;
                  retry_d       = '0;
                  drop_d        = 1'b1;
               end else begin
                  retry_d = retry_q + 4'd1;
               end
`else
               // Count is informational only here; saturate so it never wraps.
               if (int'(retry_q) < RETRY_LIMIT) retry_d = retry_q + 4'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A new request in the same cycle as the clear keeps the bit set.
   assign pending_d = (pending_q & ~clr) | irq_req;
   assign mask_d    = cfg_interrupt_msi_mask_update ? cfg_interrupt_msi_data : mask_q;

   always_comb begin
      pstat_d = '0;
      for (int i = 0; i < IRQ_COUNT; i++) begin
         pstat_d[5'(i) & vmask] = pstat_d[5'(i) & vmask] | pending_q[i];
      end
      pstat_d    = pstat_d & mask_q;
      pstat_de_d = (pstat_d != pstat_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         mask_q     <= '0;
         rr_ptr_q   <= '0;
         winner_q   <= '0;
         retry_q    <= '0;
         int_q      <= '0;
         pstat_q    <= '0;
         pstat_de_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         retry_q    <= retry_d;
         int_q      <= int_d;
         pstat_q    <= pstat_d;
         pstat_de_q <= pstat_de_d;
      end
   end

`ifdef MSI_RETRY_LIMIT_EN
   logic       drop_q;
   logic [4:0] drop_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q     <= 1'b0;
         drop_idx_q <= '0;
      end else begin
         drop_q <= drop_d;
         if (drop_d) drop_idx_q <= winner_q;
      end
   end

   assign status_irq_drop       = drop_q;
   assign status_irq_drop_index = drop_idx_q;
`else
   logic unused_drop;
   assign unused_drop           = drop_d;
   assign status_irq_drop       = 1'b0;
   assign status_irq_drop_index = 5'd0;
`endif

   assign cfg_interrupt_msi_select                      = 4'd0;
   assign cfg_interrupt_msi_int                         = int_q;
   assign cfg_interrupt_msi_pending_status              = pstat_q;
   assign cfg_interrupt_msi_pending_status_data_enable  = pstat_de_q;
   assign cfg_interrupt_msi_pending_status_function_num = 4'd0;

endmodule

// File: tb/tb_pcie_us_msi_arb.sv
// tb/tb_pcie_us_msi_arb.sv - directed self-checking bench for pcie_us_msi_arb
module tb_pcie_us_msi_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] irq_req;
   logic [3:0]  msi_en;
   logic [11:0] msi_mm;
   logic        mask_upd;
   logic [31:0] mask_data;
   logic [3:0]  msi_sel;
   logic [31:0] msi_int;
   logic        sent;
   logic        fail;
   logic [31:0] pstat;
   logic        pstat_de;
   logic [3:0]  pstat_fn;
   logic        drop;
   logic [4:0]  drop_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pcie_us_msi_arb #(.IRQ_COUNT(32), .RETRY_LIMIT(4)) dut (
      .clk                                           (clk),
      .rst_n                                         (rst_n),
      .irq_req                                       (irq_req),
      .cfg_interrupt_msi_enable                      (msi_en),
      .cfg_interrupt_msi_mmenable                    (msi_mm),
      .cfg_interrupt_msi_mask_update                 (mask_upd),
      .cfg_interrupt_msi_data                        (mask_data),
      .cfg_interrupt_msi_select                      (msi_sel),
      .cfg_interrupt_msi_int                         (msi_int),
      .cfg_interrupt_msi_sent                        (sent),
      .cfg_interrupt_msi_fail                        (fail),
      .cfg_interrupt_msi_pending_status              (pstat),
      .cfg_interrupt_msi_pending_status_data_enable  (pstat_de),
      .cfg_interrupt_msi_pending_status_function_num (pstat_fn),
      .status_irq_drop                               (drop),
      .status_irq_drop_index                         (drop_idx)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_irq(input logic [31:0] bits);
      irq_req = bits;
      tick;
      irq_req = '0;
   endtask

   task automatic expect_int(input string tag, input logic [31:0] exp);
      int n = 0;
      while (msi_int == 32'd0 && n < 20) begin
         tick;
         n++;
      end
      check(tag, msi_int, exp);
      check({tag, "_lat"}, 32'(n), 32'd2);
   endtask

   task automatic ack(input logic ok);
      if (ok) sent = 1'b1;
      else    fail = 1'b1;
      tick;
      sent = 1'b0;
      fail = 1'b0;
   endtask

   task automatic quiet(input string tag, input int cycles);
      int hits = 0;
      repeat (cycles) begin
         tick;
         if (msi_int != 32'd0) hits++;
      end
      check(tag, 32'(hits), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; irq_req = '0; msi_en = 4'h1; msi_mm = 12'd5;
      mask_upd = 1'b0; mask_data = '0; sent = 1'b0; fail = 1'b0;
      tick; tick;
      check("rst_int", msi_int, 32'd0);
      check("rst_pstat", pstat, 32'd0);
      check("rst_de", {31'd0, pstat_de}, 32'd0);
      check("rst_drop", {26'd0, drop, drop_idx}, 32'd0);
      check("rst_consts", {24'd0, msi_sel, pstat_fn}, 32'd0);
      rst_n = 1'b1;
      tick;

      // single request, vector == source
      pulse_irq(32'h8);
      expect_int("t1_int", 32'h8);
      tick;
      check("t1_pulse", msi_int, 32'd0);
      ack(1'b1);
      quiet("t1_noreissue", 8);

      // two simultaneous requests from rr_ptr = 0, then pointer continues at 8
      rst_n = 1'b0; tick; rst_n = 1'b1; tick;
      pulse_irq(32'h84);
      expect_int("t2_first", 32'h4);
      ack(1'b1);
      expect_int("t2_second", 32'h80);
      ack(1'b1);
      pulse_irq(32'h208);
      expect_int("t2_rr9", 32'h200);
      ack(1'b1);
      expect_int("t2_rr3", 32'h8);
      ack(1'b1);

      // two granted vectors fold sources
      msi_mm = 12'd1;
      pulse_irq(32'h20);
      expect_int("t3_src5", 32'h2);
      ack(1'b1);
      pulse_irq(32'h10);
      expect_int("t3_src4", 32'h1);
      ack(1'b1);

      // mmenable above 5 clamps to 32 vectors; pointer wraps 31 -> 0
      msi_mm = 12'd7;
      pulse_irq(32'h4000_0000);
      expect_int("t7_src30", 32'h4000_0000);
      ack(1'b1);
      pulse_irq(32'h21);
      expect_int("t7_wrap0", 32'h1);
      ack(1'b1);
      expect_int("t7_then5", 32'h20);
      ack(1'b1);
      msi_mm = 12'd5;

      // masked vector goes to pending_status instead of being issued
      mask_upd = 1'b1; mask_data = 32'h1; tick; mask_upd = 1'b0;
      pulse_irq(32'h1);
      check("t4_pstat_early", pstat, 32'd0);
      tick;
      check("t4_pstat", pstat, 32'h1);
      check("t4_de", {31'd0, pstat_de}, 32'd1);
      tick;
      check("t4_de_pulse", {31'd0, pstat_de}, 32'd0);
      quiet("t4_masked", 6);
      mask_upd = 1'b1; mask_data = 32'h0; tick; mask_upd = 1'b0;
      expect_int("t4_unmask", 32'h1);
      check("t4_pstat_clr", pstat, 32'd0);
      ack(1'b1);

      // retries on fail, same source reissued
      pulse_irq(32'h200);
      expect_int("t5_issue1", 32'h200);
      for (int r = 0; r < 3; r++) begin
         ack(1'b0);
         check("t5_nodrop", {31'd0, drop}, 32'd0);
         expect_int("t5_retry", 32'h200);
      end
      ack(1'b1);
      check("t5_nodrop_sent", {31'd0, drop}, 32'd0);
      quiet("t5_cleared", 8);

`ifdef MSI_RETRY_LIMIT_EN
      pulse_irq(32'h800);
      expect_int("t8_issue", 32'h800);
      for (int r = 0; r < 3; r++) begin
         ack(1'b0);
         check("t8_nodrop", {31'd0, drop}, 32'd0);
         expect_int("t8_retry", 32'h800);
      end
      ack(1'b0);
      check("t8_drop", {31'd0, drop}, 32'd1);
      check("t8_drop_idx", {27'd0, drop_idx}, 32'd11);
      tick;
      check("t8_drop_pulse", {31'd0, drop}, 32'd0);
      quiet("t8_dropped", 8);
`endif

      // reset while waiting for sent
      pulse_irq(32'h2);
      expect_int("t6_issue", 32'h2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_int", msi_int, 32'd0);
      check("t6_rst_pstat", pstat, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      ack(1'b1);
      quiet("t6_ignored", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
